// File: rtl/irq_sched_pkg.sv
// irq_sched_pkg: FSM state encoding, register addresses and ICTRL bit positions for irq_sched.
package irq_sched_pkg;
    typedef enum logic [1:0] {IDLE, REQ, SERV} state_e;
    localparam logic [1:0] ADDR_IMASK = 2'd0;
    localparam logic [1:0] ADDR_IPEND = 2'd1;
    localparam logic [1:0] ADDR_ICTRL = 2'd2;
    localparam int GIE_BIT    = 0;
    localparam int CUR_ID_LSB = 8;
    localparam int BUSY_BIT   = 16;
endpackage

// File: rtl/irq_sched_if.sv
// irq_sched_if: device-bus register port plus CPU req/ack/eret handshake of irq_sched.
interface irq_sched_if #(parameter int ID_W = 2) ();
    logic            we_i;
    logic [3:2]      addr_i;
    logic [31:0]     data_in;
    logic [31:0]     data_out;
    logic            int_req_o;
    logic [ID_W-1:0] int_id_o;
    logic            int_ack_i;
    logic            eret_i;
    modport master (output we_i, addr_i, data_in, int_ack_i, eret_i,
                    input data_out, int_req_o, int_id_o);
    modport slave (input we_i, addr_i, data_in, int_ack_i, eret_i,
                   output data_out, int_req_o, int_id_o);
endinterface

// File: rtl/irq_prio_sel.sv
// irq_prio_sel: picks the first eligible source searching upward (with wrap) from start_i.
module irq_prio_sel #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_SRC-1:0] elig_i,
    input  logic [ID_W-1:0]  start_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  id_o
);
    logic [ID_W-1:0] cand;
    // Scan from the far end so the candidate closest to start_i is written last and wins.
    always_comb begin
        valid_o = 1'b0;
        id_o = '0;
        cand = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = ID_W'((int'(start_i) + k) % N_SRC);
            if (elig_i[cand]) begin
                valid_o = 1'b1;
                id_o = cand;
            end
        end
    end
endmodule

// File: rtl/irq_sched.sv
// irq_sched: latches and masks IRQ pulses, presents one at a time to the CPU via req/ack/eret.
// Define IRQ_SCHED_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index-first.
module irq_sched
    import irq_sched_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] irq_src_i,
    irq_sched_if.slave       bus
);
    logic [N_SRC-1:0] imask_q, imask_d, ipend_q, ipend_d, elig;
    logic             gie_q, gie_d;
    state_e           state_q, state_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d, start, sel_id;
    logic             sel_valid, ack, wr_mask, wr_pend, wr_ctrl, unused_data;
    logic [31:0]      ctrl_word;

    assign wr_mask = bus.we_i && bus.addr_i == ADDR_IMASK;
    assign wr_pend = bus.we_i && bus.addr_i == ADDR_IPEND;
    assign wr_ctrl = bus.we_i && bus.addr_i == ADDR_ICTRL;
    assign ack = state_q == REQ && bus.int_ack_i;
    assign elig = gie_q ? ipend_q & imask_q : '0;
    assign imask_d = wr_mask ? bus.data_in[N_SRC-1:0] : imask_q;
    assign gie_d = wr_ctrl ? bus.data_in[GIE_BIT] : gie_q;
    // Clears first, then new pulses OR in so a same-cycle set always survives.
    assign ipend_d = (ipend_q & ~(wr_pend ? bus.data_in[N_SRC-1:0] : '0)
                     & ~(ack ? N_SRC'(1) << cur_id_q : '0)) | irq_src_i;
    assign unused_data = ^bus.data_in;
    assign ctrl_word = (32'(gie_q) << GIE_BIT) | (32'(cur_id_q) << CUR_ID_LSB)
                     | (32'(state_q != IDLE) << BUSY_BIT);

`ifdef IRQ_SCHED_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_q, last_d;
    assign last_d = ack ? cur_id_q : last_q;
    assign start = (32'(last_q) == N_SRC - 1) ? '0 : last_q + 1'b1;
    always_ff @(posedge clk_i) last_q <= rst_i ? ID_W'(N_SRC - 1) : last_d;
`else
    assign start = '0;
`endif

    irq_prio_sel #(.N_SRC(N_SRC), .ID_W(ID_W)) u_sel (
        .elig_i (elig),
        .start_i(start),
        .valid_o(sel_valid),
        .id_o   (sel_id)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            imask_q  <= '0;
            ipend_q  <= '0;
            gie_q    <= 1'b0;
            cur_id_q <= '0;
        end else begin
            state_q  <= state_d;
            imask_q  <= imask_d;
            ipend_q  <= ipend_d;
            gie_q    <= gie_d;
            cur_id_q <= cur_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_id_d = cur_id_q;
        if (state_q == IDLE && sel_valid) begin
            state_d = REQ;
            cur_id_d = sel_id;
        end else if (state_q == REQ)
            state_d = ack ? SERV
                    : (!gie_q || !imask_q[cur_id_q] || !ipend_q[cur_id_q]) ? IDLE : REQ;
        else if (state_q == SERV && bus.eret_i)
            state_d = IDLE;
    end

    always_comb begin
        bus.int_req_o = state_q == REQ;
        bus.int_id_o = cur_id_q;
        bus.data_out = bus.addr_i == ADDR_IMASK ? 32'(imask_q)
                     : bus.addr_i == ADDR_IPEND ? 32'(ipend_q)
                     : bus.addr_i == ADDR_ICTRL ? ctrl_word : '0;
    end
endmodule

// File: doc/irq_sched.md
Name: irq_sched

Overview:
- Interrupt scheduler between the timer/peripheral IRQ lines and the multicycle CPU.
- Latches one-cycle IRQ pulses into a pending register and masks them per source.
- Picks one source by priority and presents it to the CPU with a req/ack handshake.
- Blocks further requests until the CPU signals exception return; configured over the same word-addressed device bus as the timer.

Parameters:
- N_SRC, 4, number of interrupt sources (1..2**ID_W)
- ID_W, 2, width of the source id

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  synchronous active-high reset
- irq_src_i  in  N_SRC  IRQ inputs; any cycle sampled high sets that pending bit
- we_i  in  1  register write strobe
- addr_i  in  2 ([3:2])  register select
- data_in  in  32  write data
- data_out  out  32  read data, combinational from addr_i
- int_req_o  out  1  interrupt request to CPU
- int_id_o  out  ID_W  id of requested/in-service source
- int_ack_i  in  1  CPU accepts the request (takes exception)
- eret_i  in  1  CPU returns from handler

Behaviour:
- Register map:
  - 00 IMASK: RW, bits [N_SRC-1:0]; 1 = enabled.
  - 01 IPEND: read returns pending; write-1-to-clear.
  - 10 ICTRL: bit0 GIE is RW; bit16 BUSY is RO (state != IDLE); bits [8+ID_W-1:8] CUR_ID are RO; all other bits read 0.
  - 11: reserved; reads 0, writes ignored.
  - Unused high bits of IMASK/IPEND read 0.
- Reset (sync): IMASK=0, IPEND=0, GIE=0, state=IDLE, int_req_o=0, int_id_o=0, CUR_ID=0.
- Pending update per cycle, in order:
  - clear bits from an IPEND W1C write;
  - clear the CUR_ID bit on accepted ack;
  - then OR in irq_src_i. Set wins over any same-cycle clear.
- eligible = IPEND & IMASK, gated by GIE.
- FSM:
  - IDLE: if eligible != 0, latch the selected id into CUR_ID and go to REQ. Otherwise stay.
  - REQ: int_req_o=1 and int_id_o=CUR_ID, both stable.
    - If int_ack_i: clear IPEND[CUR_ID], go to SERV.
    - Else if GIE==0, or IMASK[CUR_ID]==0, or IPEND[CUR_ID]==0 (SW cleared it): withdraw by going to IDLE. Pending bits are retained.
  - SERV: int_req_o=0, int_id_o holds CUR_ID, no nesting. On eret_i, go to IDLE.
- Handshake rules:
  - int_ack_i is ignored outside REQ.
  - eret_i is ignored outside SERV.
  - Ack and withdraw in the same cycle: ack wins.
- Latency:
  - Pulse in cycle t sets IPEND at edge t+1.
  - int_req_o is high from edge t+2 (source enabled, GIE=1, FSM in IDLE).
  - After eret in cycle t, a still-eligible source is requested from edge t+2.
- Priority (default): fixed, lowest index wins.
- Register writes take effect at the next edge. A write in the same cycle as an FSM decision uses the pre-write values.
- Reset asserted in any state overrides everything else in that cycle.

Optional Feature:
- Macro: IRQ_SCHED_ROUND_ROBIN_EN.
- Defined: rotating priority. Search starts at (last acked id + 1) mod N_SRC. Last-acked pointer resets to N_SRC-1, so the first search starts at 0. Only ack updates the pointer; a withdrawal does not.
- Undefined: fixed lowest-index priority; no pointer register.

Decomposition:
- Package irq_sched_pkg:
  - FSM state enum (IDLE, REQ, SERV);
  - address constants (ADDR_IMASK, ADDR_IPEND, ADDR_ICTRL);
  - ICTRL bit positions (GIE_BIT=0, CUR_ID_LSB=8, BUSY_BIT=16).
- One sub-module, irq_prio_sel: combinational. Inputs are the eligible vector and a start index; outputs are valid and the selected id. Start index is tied to 0 when round-robin is off.

Test Plan:
- Basic request/ack/eret:
  - Stimulus: IMASK=4'b0100, GIE=1, pulse irq_src_i[2] at cycle 10.
  - Response: IPEND=4'b0100 at 11; int_req_o=1, int_id_o=2 from 12.
  - Ack at 14: int_req_o=0 at 15, IPEND=0, BUSY=1.
  - eret at 18: BUSY=0 at 19.
- Fixed priority and no nesting:
  - Stimulus: IMASK=4'b1111; pulse sources 3 and 1 in the same cycle.
  - Response: id 1 requested first. Pulse source 0 during SERV: no request until eret, then id 0 is requested, then id 3.
- Masking and withdrawal:
  - Pulse source 2 with IMASK=0: IPEND=4'b0100, int_req_o stays 0.
  - Set IMASK[2]=1: request appears 2 cycles later.
  - Clear GIE while in REQ: int_req_o=0 next cycle, IPEND still 4'b0100.
- Simultaneous set/clear:
  - W1C IPEND=4'b0001 in the same cycle irq_src_i[0] pulses: IPEND[0]=1 afterward.
  - Ack of id 0 in the same cycle source 0 pulses: IPEND[0]=1 afterward.
- Reset mid-operation:
  - Assert rst_i for 1 cycle during REQ.
  - Response: int_req_o=0, IMASK=IPEND=0, GIE=0, state IDLE at the next edge. Reads of addr 11 return 0.
- Round-robin (with IRQ_SCHED_ROUND_ROBIN_EN):
  - Stimulus: sources 0,1,2 held pending; ack-and-eret each in turn.
  - Response: served order 0,1,2,0.
  - Same stimulus without the macro: served order 0,0,0 while source 0 keeps re-pulsing.
